// File: rtl/mem_responder_pkg.sv
// Shared definitions for the EXU data-memory responder: FSM encodings,
// latency limits and the byte-lane mask expander.
package mem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    // Bit i of the lane mask enables byte [8i+7:8i].
    function automatic logic [31:0] lane_expand(input logic [3:0] mask);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{mask[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_responder_sram_be.sv
// Synchronous single-port word RAM with per-byte write enables.
// Read-before-write on the same edge; no reset state.
module mem_sram_be #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one load/store at a time, services it against
// the byte-lane RAM after LATENCY cycles and pulses resp_valid with rdata/err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAddr,
    input  logic [31:0] memData,
    input  logic        readWr,
    input  logic        writeWr,
    input  logic [3:0]  rmask,
    input  logic [3:0]  wmask,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW           = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD    = 4'(LATENCY - 1);
    localparam bit          SINGLE_CYCLE = (LATENCY == 1);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("mem_responder: LATENCY must lie in 1..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: DEPTH_WORDS must be a power of two >= 4");
    end

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [3:0]    rmask_q;
    logic [3:0]    wmask_q;
    logic          store_q;
    logic          bad_q;
    logic [3:0]    lane_q;
    logic [31:0]   ram_q;

    logic          accept;
    logic          req_oor;
    logic          req_bad;
    logic          use_inputs;
    logic          enter_resp;
    logic [AW-1:0] op_addr;
    logic [31:0]   op_data;
    logic [3:0]    op_rmask;
    logic [3:0]    op_wmask;
    logic          op_store;
    logic          op_bad;
    logic          ram_en;
    logic [3:0]    ram_we;

    assign req_ready  = !rst && (state == ST_IDLE || state == ST_RESP);
    assign accept     = req_ready && (readWr || writeWr);
    assign req_oor    = (memAddr >> (AW + 2)) != 32'd0;
    assign req_bad    = (readWr && writeWr) || req_oor;

    // With LATENCY 1 the RAM access happens on the accept edge itself, so the
    // operation is taken straight from the request inputs instead of the capture regs.
    assign use_inputs = SINGLE_CYCLE && accept;
    assign enter_resp = use_inputs || (state == ST_WAIT && cnt <= 4'd1);

    always_comb begin
        if (use_inputs) begin
            op_addr  = memAddr[AW+1:2];
            op_data  = memData;
            op_rmask = rmask;
            op_wmask = wmask;
            op_store = writeWr;
            op_bad   = req_bad;
        end else begin
            op_addr  = addr_q;
            op_data  = data_q;
            op_rmask = rmask_q;
            op_wmask = wmask_q;
            op_store = store_q;
            op_bad   = bad_q;
        end
    end

    assign ram_en = enter_resp && !op_bad && !rst;
    assign ram_we = (ram_en && op_store) ? op_wmask : 4'd0;

    mem_sram_be #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (op_addr),
        .wdata(op_data),
        .rdata(ram_q)
    );

    // lane_q is zero for stores, errors and reset, which forces rdata to 0.
    assign rdata = ram_q & lane_expand(lane_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            lane_q     <= '0;
        end else begin
            resp_valid <= enter_resp;
            if (enter_resp) begin
                err    <= op_bad;
                lane_q <= (op_bad || op_store) ? 4'd0 : op_rmask;
            end
            if (accept) begin
                addr_q  <= memAddr[AW+1:2];
                data_q  <= memData;
                rmask_q <= rmask;
                wmask_q <= wmask;
                store_q <= writeWr;
                bad_q   <= req_bad;
                if (SINGLE_CYCLE) begin
                    state <= ST_RESP;
                end else begin
                    state <= ST_WAIT;
                    cnt   <= WAIT_LOAD;
                end
            end else if (state == ST_WAIT) begin
                // cnt == 1 here is the cycle whose decrement would reach 0.
                if (cnt <= 4'd1) begin
                    state <= ST_RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (LATENCY 2, 3 and 1)
// share the request bus; only the selected one sees readWr/writeWr.
module tb_mem_responder;

    localparam int unsigned NDUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memAddr = '0;
    logic [31:0] memData = '0;
    logic [3:0]  rmask = '0;
    logic [3:0]  wmask = '0;
    logic        rd_v    [NDUT];
    logic        wr_v    [NDUT];
    logic        ready_v [NDUT];
    logic        valid_v [NDUT];
    logic        err_v   [NDUT];
    logic [31:0] rdata_v [NDUT];

    int unsigned sel = 0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [NDUT][1024];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        mem_responder #(
            .DEPTH_WORDS(1024),
            .LATENCY    (L)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .memAddr   (memAddr),
            .memData   (memData),
            .readWr    (rd_v[g]),
            .writeWr   (wr_v[g]),
            .rmask     (rmask),
            .wmask     (wmask),
            .req_ready (ready_v[g]),
            .resp_valid(valid_v[g]),
            .rdata     (rdata_v[g]),
            .err       (err_v[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lat_of(input int unsigned s);
        case (s)
            0: return 2;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Response monitor: every resp_valid must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid_v[sel] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: dut %0d cycle %0d resp_valid=1, expected no response", sel, cyc);
            end else begin
                e = exp_q.pop_front();
                if (rdata_v[sel] !== e.rdata || err_v[sel] !== e.err || cyc != e.due) begin
                    errors++;
                    $display("FAIL resp: dut %0d got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                             sel, rdata_v[sel], err_v[sel], cyc, e.rdata, e.err, e.due);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] rm, input logic [3:0] wm,
                         output int unsigned stall);
        exp_t        e;
        logic        bad;
        int unsigned w;
        memAddr   = addr;
        memData   = data;
        rmask     = rm;
        wmask     = wm;
        rd_v[sel] = rd;
        wr_v[sel] = wr;
        stall = 0;
        while (ready_v[sel] !== 1'b1 && stall < 64) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 64) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut %0d req_ready=%b after 64 cycles, expected 1", sel, ready_v[sel]);
            rd_v[sel] = 1'b0;
            wr_v[sel] = 1'b0;
            return;
        end
        bad = (rd && wr) || (addr[31:12] != 20'd0);
        w = int'(addr[11:2]);
        e.err   = bad;
        e.rdata = '0;
        e.due   = cyc + lat_of(sel);
        if (!bad && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wm[i]) model[sel][w][8*i +: 8] = data[8*i +: 8];
            end
        end else if (!bad && rd) begin
            e.rdata = model[sel][w] & expand(rm);
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        rd_v[sel] = 1'b0;
        wr_v[sel] = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: dut %0d has %0d responses outstanding, expected 0", sel, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ready_v[d] !== 1'b0 || valid_v[d] !== 1'b0 || err_v[d] !== 1'b0 || rdata_v[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_values: dut %0d ready=%b valid=%b err=%b rdata=%h, expected 0 0 0 00000000",
                         d, ready_v[d], valid_v[d], err_v[d], rdata_v[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ready_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset: dut %0d req_ready=%b, expected 1", d, ready_v[d]);
            end
        end
    endtask

    task automatic test_store_load();
        int unsigned s;
        sel = 0;
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'h0, 4'hF, s);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, s);
        // zero masks: no RAM change and rdata 0
        issue(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 4'h0, s);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'h0, s);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, s);
        drain();
    endtask

    task automatic test_byte_lanes();
        int unsigned s;
        sel = 0;
        issue(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'h0, 4'hF, s);
        issue(1'b0, 1'b1, 32'h20, 32'h11223344, 4'h0, 4'h5, s);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h6, 4'h0, s);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h9, 4'h0, s);
        drain();
    endtask

    task automatic test_back_to_back();
        int unsigned s0;
        int unsigned s1;
        sel = 1;
        issue(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'h0, 4'hF, s0);
        issue(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 4'h0, s1);
        checks++;
        if (s1 != 2) begin
            errors++;
            $display("FAIL b2b_stall: req_ready low for %0d cycles, expected 2", s1);
        end
        drain();
    endtask

    task automatic test_errors();
        int unsigned s;
        sel = 0;
        issue(1'b0, 1'b1, 32'h0, 32'h01020304, 4'h0, 4'hF, s);
        issue(1'b0, 1'b1, 32'h0000_1000, 32'hFFFFFFFF, 4'h0, 4'hF, s);
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 4'h0, s);
        issue(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 4'hF, s);
        issue(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 4'h0, s);
        drain();
    endtask

    task automatic test_reset_in_wait();
        int unsigned s;
        int unsigned seen;
        sel = 1;
        issue(1'b0, 1'b1, 32'h8, 32'h12345678, 4'h0, 4'hF, s);
        drain();
        memAddr = 32'h8;
        memData = 32'h00000055;
        wmask   = 4'hF;
        wr_v[sel] = 1'b1;
        checks++;
        if (ready_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_ready: req_ready=%b before store, expected 1", ready_v[sel]);
        end
        @(posedge clk);
        @(negedge clk);
        wr_v[sel] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_v[sel] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_ready_low: req_ready=%b during reset, expected 0", ready_v[sel]);
        end
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_v[sel] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || ready_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_discard: %0d responses, req_ready=%b, expected 0 responses, req_ready=1", seen, ready_v[sel]);
        end
        issue(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 4'h0, s);
        drain();
    endtask

    task automatic test_lat1_sweep();
        int unsigned s;
        int unsigned stalls;
        sel = 2;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'h0, 4'hF, s);
            stalls += s;
        end
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 1'b1, 32'h100 + 32'(4 * $urandom_range(15, 0)), $urandom,
                  4'h0, 4'($urandom_range(15, 0)), s);
            stalls += s;
        end
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 1'b0, 32'h100 + 32'(4 * $urandom_range(15, 0)), 32'h0,
                  4'($urandom_range(15, 0)), 4'h0, s);
            stalls += s;
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL lat1_stall: %0d stall cycles across 48 requests, expected 0", stalls);
        end
        drain();
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rd_v[d] = 1'b0;
            wr_v[d] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_reset_in_wait();
        test_lat1_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
